// File: rtl/multiplier_pipe.sv
// Pipelined integer multiplier for the MULT/MULTU issue queue.
// The full 2*WIDTH product is formed at issue and carried with its tag through STAGES slots.
module multiplier_pipe #(
  parameter int WIDTH  = 32,
  parameter int TAG_W  = 6,
  parameter int STAGES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issuemult_enable,
  input  logic               issuemult_signed,
  input  logic [WIDTH-1:0]   issuemult_rsdata,
  input  logic [WIDTH-1:0]   issuemult_rtdata,
  input  logic [TAG_W-1:0]   issuemult_rdtag,
  input  logic               issuemult_flush,
  input  logic               cdb_grant,
  output logic               issuemult_ready,
  output logic               issuemult_valid_out,
  output logic [WIDTH-1:0]   issuemult_out_hi,
  output logic [WIDTH-1:0]   issuemult_out_lo,
  output logic [TAG_W-1:0]   issuemult_rdtag_out
);

  localparam int PW = 2 * WIDTH;

  logic [STAGES-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag  [STAGES];
  logic [PW-1:0]     r_prod [STAGES];

  logic              w_stall;
  logic              w_accept;
  logic [PW-1:0]     w_rs_ext;
  logic [PW-1:0]     w_rt_ext;
  logic [PW-1:0]     w_prod;

  // A result parked at the tail without a CDB grant freezes the whole pipe.
  assign w_stall         = r_valid[STAGES-1] & ~cdb_grant;
  assign issuemult_ready = ~w_stall;
  assign w_accept        = issuemult_enable & ~w_stall & ~issuemult_flush;

  // Sign- or zero-extend to product width; the low PW bits of the modular product are exact in both modes.
  always_comb begin
    w_rs_ext = {{WIDTH{issuemult_signed & issuemult_rsdata[WIDTH-1]}}, issuemult_rsdata};
    w_rt_ext = {{WIDTH{issuemult_signed & issuemult_rtdata[WIDTH-1]}}, issuemult_rtdata};
    w_prod   = w_rs_ext * w_rt_ext;
  end

  // Slot shift register; bubbles and squashed slots carry zero data so the tail reads 0 when invalid.
  always_ff @(posedge clk) begin
    if (!reset || issuemult_flush) begin
      r_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_tag[i]  <= '0;
        r_prod[i] <= '0;
      end
    end else if (!w_stall) begin
      r_valid[0] <= w_accept;
      r_tag[0]   <= w_accept ? issuemult_rdtag : '0;
      r_prod[0]  <= w_accept ? w_prod : '0;
      for (int i = 1; i < STAGES; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
        r_prod[i]  <= r_prod[i-1];
      end
    end
  end

  assign issuemult_valid_out = r_valid[STAGES-1];
  assign issuemult_out_hi    = r_prod[STAGES-1][PW-1:WIDTH];
  assign issuemult_out_lo    = r_prod[STAGES-1][WIDTH-1:0];
  assign issuemult_rdtag_out = r_tag[STAGES-1];

endmodule

// File: tb/tb_multiplier_pipe.sv
// Self-checking bench for multiplier_pipe: directed scenarios plus a randomized run scored against an in-order queue model.
module tb_multiplier_pipe;

  localparam int WIDTH  = 32;
  localparam int TAG_W  = 6;
  localparam int STAGES = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic             sgn;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [TAG_W-1:0] tag;
  logic             flush;
  logic             grant;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [TAG_W-1:0] tag_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  always #5 clk = ~clk;

  multiplier_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W), .STAGES(STAGES)) dut (
    .clk(clk), .reset(reset),
    .issuemult_enable(en), .issuemult_signed(sgn),
    .issuemult_rsdata(rs), .issuemult_rtdata(rt), .issuemult_rdtag(tag),
    .issuemult_flush(flush), .cdb_grant(grant),
    .issuemult_ready(ready), .issuemult_valid_out(valid),
    .issuemult_out_hi(hi), .issuemult_out_lo(lo), .issuemult_rdtag_out(tag_out)
  );

  // Reference product from plain integer arithmetic.
  function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
      return 64'(p);
    end else begin
      return {32'd0, a} * {32'd0, b};
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    en = 1'b0; flush = 1'b0; grant = 1'b1; sgn = 1'b0;
    rs = 32'd0; rt = 32'd0; tag = 6'd0;
  endtask

  task automatic test_reset;
    reset = 1'b0; en = 1'b1; sgn = 1'b1; rs = 32'h1234_5678; rt = 32'h9ABC_DEF0;
    tag = 6'h15; flush = 1'b0; grant = 1'b0;
    tick; tick;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
    n_checks++; if (tag_out !== 6'd0) begin n_fail++; $display("FAIL reset_tag: got %h expected 0", tag_out); end
    reset = 1'b1; idle;
    tick;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_noresult: got %b expected 0", valid); end
  endtask

  task automatic test_basic_latency;
    idle; rs = 32'h0000_0003; rt = 32'h0000_0005; tag = 6'h2A; en = 1'b1;
    tick; en = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_early c%0d: got %b expected 0", k, valid); end
      tick;
    end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", valid); end
    n_checks++; if (lo !== 32'h0000_000F) begin n_fail++; $display("FAIL basic_lo: got %h expected 0000000f", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL basic_hi: got %h expected 0", hi); end
    n_checks++; if (tag_out !== 6'h2A) begin n_fail++; $display("FAIL basic_tag: got %h expected 2a", tag_out); end
    tick;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_after: got %b expected 0", valid); end
  endtask

  task automatic test_signed_unsigned;
    idle; rs = 32'hFFFF_FFFF; rt = 32'h0000_0002;
    en = 1'b1; sgn = 1'b1; tag = 6'd1;
    tick;
    sgn = 1'b0; tag = 6'd2;
    tick;
    en = 1'b0; sgn = 1'b1;
    tick; tick;
    n_checks++; if (valid !== 1'b1 || tag_out !== 6'd1) begin n_fail++; $display("FAIL su_signed_tag: got v=%b tag=%h expected v=1 tag=01", valid, tag_out); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL su_signed_hi: got %h expected ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL su_signed_lo: got %h expected fffffffe", lo); end
    tick;
    n_checks++; if (valid !== 1'b1 || tag_out !== 6'd2) begin n_fail++; $display("FAIL su_unsigned_tag: got v=%b tag=%h expected v=1 tag=02", valid, tag_out); end
    n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL su_unsigned_hi: got %h expected 00000001", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL su_unsigned_lo: got %h expected fffffffe", lo); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_p [4];
    idle;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; sgn = 1'($urandom_range(1, 0)); rs = $urandom; rt = $urandom; tag = 6'(i + 1);
      exp_p[i] = ref_prod(sgn, rs, rt);
      tick;
    end
    en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (valid !== 1'b1 || tag_out !== 6'(j + 1)) begin n_fail++; $display("FAIL b2b_tag%0d: got v=%b tag=%h expected v=1 tag=%h", j, valid, tag_out, 6'(j + 1)); end
      n_checks++; if ({hi, lo} !== exp_p[j]) begin n_fail++; $display("FAIL b2b_prod%0d: got %h expected %h", j, {hi, lo}, exp_p[j]); end
      tick;
    end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_after: got %b expected 0", valid); end
  endtask

  task automatic test_backpressure;
    logic [63:0] pa;
    logic [63:0] pb;
    idle;
    en = 1'b1; sgn = 1'b0; rs = $urandom; rt = $urandom; tag = 6'd5; pa = ref_prod(sgn, rs, rt);
    tick;
    sgn = 1'b1; rs = $urandom; rt = $urandom; tag = 6'd6; pb = ref_prod(sgn, rs, rt);
    tick;
    en = 1'b0; grant = 1'b0;
    tick; tick;
    en = 1'b1; sgn = 1'b0; rs = 32'h0000_0007; rt = 32'h0000_0007; tag = 6'd7;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 0", k, ready); end
      n_checks++; if (valid !== 1'b1 || tag_out !== 6'd5) begin n_fail++; $display("FAIL bp_hold_tag%0d: got v=%b tag=%h expected v=1 tag=05", k, valid, tag_out); end
      n_checks++; if ({hi, lo} !== pa) begin n_fail++; $display("FAIL bp_hold_prod%0d: got %h expected %h", k, {hi, lo}, pa); end
      tick;
    end
    en = 1'b0; grant = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", ready); end
    tick;
    n_checks++; if (valid !== 1'b1 || tag_out !== 6'd6) begin n_fail++; $display("FAIL bp_next_tag: got v=%b tag=%h expected v=1 tag=06", valid, tag_out); end
    n_checks++; if ({hi, lo} !== pb) begin n_fail++; $display("FAIL bp_next_prod: got %h expected %h", {hi, lo}, pb); end
    for (int k = 0; k < STAGES + 1; k++) begin
      tick;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup%0d: got %b tag=%h expected 0", k, valid, tag_out); end
    end
  endtask

  task automatic test_flush;
    logic [63:0] pe;
    idle;
    for (int i = 0; i < 3; i++) begin
      en = 1'b1; sgn = 1'($urandom_range(1, 0)); rs = $urandom; rt = $urandom; tag = 6'(10 + i);
      tick;
    end
    flush = 1'b1; en = 1'b1; tag = 6'd13;
    tick;
    flush = 1'b0; en = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL flush_quiet%0d: got %b tag=%h expected 0", k, valid, tag_out); end
      tick;
    end
    en = 1'b1; sgn = 1'b1; rs = $urandom; rt = $urandom; tag = 6'd20; pe = ref_prod(sgn, rs, rt);
    tick;
    en = 1'b0;
    for (int k = 1; k < STAGES; k++) tick;
    n_checks++; if (valid !== 1'b1 || tag_out !== 6'd20) begin n_fail++; $display("FAIL flush_next_tag: got v=%b tag=%h expected v=1 tag=14", valid, tag_out); end
    n_checks++; if ({hi, lo} !== pe) begin n_fail++; $display("FAIL flush_next_prod: got %h expected %h", {hi, lo}, pe); end
    tick;
  endtask

  task automatic test_reset_mid_op;
    idle;
    for (int i = 0; i < 2; i++) begin
      en = 1'b1; rs = $urandom | 32'd1; rt = $urandom | 32'd1; tag = 6'(30 + i);
      tick;
    end
    reset = 1'b0; en = 1'b1; grant = 1'b1;
    tick;
    reset = 1'b1; idle;
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", valid); end
    n_checks++; if ({hi, lo, tag_out} !== 70'd0) begin n_fail++; $display("FAIL rmid_outs: got %h expected 0", {hi, lo, tag_out}); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", ready); end
    for (int k = 0; k < STAGES + 2; k++) begin
      tick;
      n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rmid_ghost%0d: got %b tag=%h expected 0", k, valid, tag_out); end
    end
  endtask

  task automatic test_random;
    exp_t        q[$];
    exp_t        e;
    logic [63:0] p;
    int          cyc = 0;
    idle;
    for (int n = 0; n < 420; n++) begin
      if (n < 400) begin
        en    = ($urandom_range(3, 0) != 0);
        grant = ($urandom_range(3, 0) != 0);
        flush = ($urandom_range(39, 0) == 0);
        if (flush) grant = 1'b0;
      end else begin
        en = 1'b0; grant = 1'b1; flush = 1'b0;
      end
      sgn = 1'($urandom_range(1, 0)); rs = $urandom; rt = $urandom; tag = 6'($urandom);
      if ($urandom_range(7, 0) == 0) rs = 32'h8000_0000;
      #1;
      n_checks++;
      if (ready !== !(valid && !grant)) begin n_fail++; $display("FAIL rand_ready c%0d: got %b valid=%b grant=%b", cyc, ready, valid, grant); end
      if (valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious c%0d: got valid tag=%h expected no result", cyc, tag_out);
        end else if ({hi, lo, tag_out} !== {q[0].hi, q[0].lo, q[0].tag} || cyc < q[0].cyc + STAGES) begin
          n_fail++;
          $display("FAIL rand_result c%0d: got %h/%h tag=%h expected %h/%h tag=%h issued c%0d",
                   cyc, hi, lo, tag_out, q[0].hi, q[0].lo, q[0].tag, q[0].cyc);
        end
        if (grant && !flush && q.size() != 0) void'(q.pop_front());
      end
      if (flush) begin
        q.delete();
      end else if (en && ready) begin
        p = ref_prod(sgn, rs, rt);
        e.hi = p[63:32]; e.lo = p[31:0]; e.tag = tag; e.cyc = cyc;
        q.push_back(e);
      end
      tick;
      cyc++;
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rand_drain: got %0d outstanding expected 0", q.size()); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle: got %b expected 0", valid); end
  endtask

  initial begin
    reset = 1'b0;
    idle;
    test_reset;
    test_basic_latency;
    test_signed_unsigned;
    test_back_to_back;
    test_backpressure;
    test_flush;
    test_reset_mid_op;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
